addr_tx_seq: RTL and testbench

ADDR_TX_SEQ -- requirements
Module: addr_tx_seq

---
 rtl/addr_tx_seq.sv | 132 +++++++++++++
 tb/tb_addr_tx_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_tx_seq.sv
// addr_tx_seq: walks an address range START_ADDR..END_ADDR and issues one
// paced transmit strobe per address to a UART data path.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous, active-low reset
//   start   - begin a sequence (sampled in IDLE only)
//   stop    - abort to IDLE; wins over everything else
//   pause   - freezes the tick divider while high
//   tx_busy - transmitter busy; holds off the next strobe
//   addr    - current address presented to ROM/UART
//   tx_en   - registered one-cycle transmit strobe
//   active  - high whenever the sequencer is not IDLE
//   done    - registered one-cycle pulse at the end of a one-shot run
module addr_tx_seq #(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2**ADDR_W - 1,
    parameter int TICK_DIV   = 4,
    parameter int MODE       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] addr,
    output logic              tx_en,
    output logic              active,
    output logic              done
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ZERO = '0;
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        ISSUE     = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [ADDR_W-1:0] addr_d;
    logic              tx_en_d;
    logic              done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= DIV_ZERO;
            addr    <= START_A;
            tx_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            addr    <= addr_d;
            tx_en   <= tx_en_d;
            done    <= done_d;
        end
    end

    // tx_en is registered alongside the ISSUE transition, so it is high
    // exactly while the FSM sits in ISSUE. addr only moves on leaving
    // ISSUE, which keeps it stable across the strobe and the cycle before.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        addr_d  = addr;
        tx_en_d = 1'b0;
        done_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            div_d   = DIV_ZERO;
            addr_d  = START_A;
        end else begin
            unique case (state_q)
                IDLE: begin
                    div_d  = DIV_ZERO;
                    addr_d = START_A;
                    if (start) begin
                        state_d = WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (!pause) begin
                        if (div_q != DIV_LAST) begin
                            div_d = div_q + DIV_ONE;
                        end else if (!tx_busy) begin
                            state_d = ISSUE;
                            tx_en_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    div_d = DIV_ZERO;
                    if (addr != END_A) begin
                        addr_d  = addr + ADDR_ONE;
                        state_d = WAIT_TICK;
                    end else if (MODE == 0) begin
                        addr_d  = START_A;
                        state_d = WAIT_TICK;
                    end else begin
                        addr_d  = START_A;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    div_d   = DIV_ZERO;
                    addr_d  = START_A;
                end
            endcase
        end
    end

    // Decoded straight from the state register so reset drops it at once.
    assign active = (state_q != IDLE);

endmodule

// File: tb/tb_addr_tx_seq.sv
// tb_addr_tx_seq: directed checks of addr_tx_seq with ADDR_W=4,
// START_ADDR=2, END_ADDR=5, TICK_DIV=3, one-shot and wrap instances.
module tb_addr_tx_seq;

    logic       clk;
    logic       rst;
    logic       start1;
    logic       start0;
    logic       stop;
    logic       pause;
    logic       tx_busy;
    logic [3:0] addr1;
    logic       tx_en1;
    logic       active1;
    logic       done1;
    logic [3:0] addr0;
    logic       tx_en0;
    logic       active0;
    logic       done0;

    int vectors    = 0;
    int miscompares = 0;

    addr_tx_seq #(
        .ADDR_W(4), .START_ADDR(2), .END_ADDR(5),
        .TICK_DIV(3), .MODE(1)
    ) u_m1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop),
        .pause(pause), .tx_busy(tx_busy), .addr(addr1),
        .tx_en(tx_en1), .active(active1), .done(done1)
    );

    addr_tx_seq #(
        .ADDR_W(4), .START_ADDR(2), .END_ADDR(5),
        .TICK_DIV(3), .MODE(0)
    ) u_m0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop),
        .pause(pause), .tx_busy(tx_busy), .addr(addr0),
        .tx_en(tx_en0), .active(active0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle1(input string tag);
        check({tag, " addr"}, 32'(addr1), 32'd2);
        check({tag, " tx_en"}, 32'(tx_en1), 32'd0);
        check({tag, " active"}, 32'(active1), 32'd0);
        check({tag, " done"}, 32'(done1), 32'd0);
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        tx_busy = 1'b0;

        // reset state, applied between clock edges
        #1 rst = 1'b0;
        #1;
        idle1("reset");
        check("reset active0", 32'(active0), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        idle1("post-reset idle");

        // one-shot run: strobes at edges 3,7,11,15, done after 16
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("m1 e0 active", 32'(active1), 32'd1);
        check("m1 e0 tx_en", 32'(tx_en1), 32'd0);
        for (int e = 1; e <= 16; e++) begin
            tick();
            check($sformatf("m1 e%0d tx_en", e), 32'(tx_en1),
                  32'((e % 4) == 3));
            check($sformatf("m1 e%0d addr", e), 32'(addr1),
                  (e < 16) ? 32'(2 + e / 4) : 32'd2);
            check($sformatf("m1 e%0d active", e), 32'(active1),
                  32'(e < 16));
            check($sformatf("m1 e%0d done", e), 32'(done1),
                  32'(e == 16));
        end

        // start held after done restarts on the next edge
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("restart active", 32'(active1), 32'd1);
        check("restart done", 32'(done1), 32'd0);
        abort();
        idle1("after stop");

        // wrap mode: 2,3,4,5,2,3 with a 4-cycle period, no done
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            check($sformatf("m0 e%0d tx_en", e), 32'(tx_en0),
                  32'((e % 4) == 3));
            check($sformatf("m0 e%0d addr", e), 32'(addr0),
                  32'(2 + (e / 4) % 4));
            check($sformatf("m0 e%0d done", e), 32'(done0), 32'd0);
        end
        abort();
        check("m0 stopped", 32'(active0), 32'd0);

        // tx_busy high across edges 2..12 stalls the first strobe
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tx_busy = 1'b1;
        for (int e = 2; e <= 12; e++) begin
            tick();
            check($sformatf("busy e%0d tx_en", e), 32'(tx_en1), 32'd0);
            check($sformatf("busy e%0d addr", e), 32'(addr1), 32'd2);
        end
        tx_busy = 1'b0;
        tick();
        check("busy e13 tx_en", 32'(tx_en1), 32'd1);
        check("busy e13 addr", 32'(addr1), 32'd2);
        abort();
        idle1("busy stopped");

        // pause for 5 edges moves the first strobe from edge 3 to 8
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pause = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            if (e == 6) pause = 1'b0;
            tick();
            check($sformatf("pause e%0d tx_en", e), 32'(tx_en1),
                  32'(e == 8));
            check($sformatf("pause e%0d addr", e), 32'(addr1), 32'd2);
        end
        abort();
        idle1("pause stopped");

        // stop and start together at edge 6: stop wins
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        check("pre-stop addr", 32'(addr1), 32'd3);
        stop = 1'b1;
        start1 = 1'b1;
        tick();
        stop = 1'b0;
        start1 = 1'b0;
        idle1("stop+start");
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("stopped c%0d tx_en", e), 32'(tx_en1), 32'd0);
            check($sformatf("stopped c%0d active", e), 32'(active1),
                  32'd0);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int e = 1; e <= 3; e++) tick();
        check("restart e3 tx_en", 32'(tx_en1), 32'd1);
        check("restart e3 addr", 32'(addr1), 32'd2);

        // async reset in the tx_en cycle at addr 4
        for (int e = 4; e <= 11; e++) tick();
        check("e11 tx_en", 32'(tx_en1), 32'd1);
        check("e11 addr", 32'(addr1), 32'd4);
        #2 rst = 1'b0;
        #1;
        idle1("async reset");
        #2 rst = 1'b1;
        tick();
        tick();
        idle1("after reset release");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
